// File: rtl/bus_demux_pkg.sv
// Shared definitions for the CPU data-side bus demultiplexer and its helpers.
// State encodings, default widths, the peripheral window base and the abort pattern.
package bus_demux_pkg;

   localparam int          DATA_W_DEF      = 32;
   localparam logic [31:0] PERIPH_BASE_DEF = 32'hFFFF_0000;
   localparam logic [31:0] ERR_DATA        = 32'hDEAD_BEEF;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1
   } state_t;

endpackage

// File: rtl/bus_demux_if.sv
// CPU-side and target-side signals of the data-bus demultiplexer.
// Handshake: a target completes a request in any cycle where its valid and ready are both 1.
interface bus_demux_if #(
   parameter int DATA_W = 32
);

   logic              cpu_req;
   logic              cpu_we;
   logic [DATA_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic              cpu_busy;
   logic [DATA_W-1:0] cpu_rdata;
   logic              cpu_done;
   logic              cpu_err;

   logic              a_valid;
   logic              a_we;
   logic [DATA_W-1:0] a_addr;
   logic [DATA_W-1:0] a_wdata;
   logic              a_ready;
   logic [DATA_W-1:0] a_rdata;

   logic              b_valid;
   logic              b_we;
   logic [DATA_W-1:0] b_addr;
   logic [DATA_W-1:0] b_wdata;
   logic              b_ready;
   logic [DATA_W-1:0] b_rdata;

   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output cpu_busy, cpu_rdata, cpu_done, cpu_err,
      output a_valid, a_we, a_addr, a_wdata,
      input  a_ready, a_rdata,
      output b_valid, b_we, b_addr, b_wdata,
      input  b_ready, b_rdata
   );

   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  cpu_busy, cpu_rdata, cpu_done, cpu_err,
      input  a_valid, a_we, a_addr, a_wdata,
      output a_ready, a_rdata,
      input  b_valid, b_we, b_addr, b_wdata,
      output b_ready, b_rdata
   );

endinterface

// File: rtl/bus_demux_timeout_ctr.sv
// Wait-cycle counter for a bus master; expire flags the last permitted wait cycle.
// Reusable by any master that must abort a request to an unresponsive target.
module bus_timeout_ctr #(
   parameter int TIMEOUT = 15
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic expire
);

   logic [7:0] cnt;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (enable) begin
         cnt <= cnt + 8'd1;
      end
   end

   // Flagged one count early so the abort lands exactly TIMEOUT cycles after issue.
   assign expire = enable && (cnt == 8'(TIMEOUT - 1));

endmodule

// File: rtl/bus_demux.sv
// Routes one registered CPU data transaction to RAM (port A) or peripherals (port B)
// by address, stalls the CPU until the target answers, and aborts on timeout.
module bus_demux
   import bus_demux_pkg::*;
#(
   parameter int                DATA_W      = DATA_W_DEF,
   parameter logic [DATA_W-1:0] PERIPH_BASE = PERIPH_BASE_DEF,
   parameter int                TIMEOUT     = 15
) (
   input  logic             clk,
   input  logic             rst_n,
   bus_demux_if.slave       bus,
   output state_t           dbg_state
);

   state_t            state, state_nxt;
   logic              req_we, req_sel;
   logic [DATA_W-1:0] req_addr, req_wdata;
   logic              done_q, err_q, done_nxt, err_nxt;
   logic [DATA_W-1:0] rdata_q, rdata_nxt;
   logic              sel_ready, expire, issuing;
   logic [DATA_W-1:0] sel_rdata;

   assign issuing   = (state == ISSUE);
   assign sel_ready = req_sel ? bus.b_ready : bus.a_ready;
   assign sel_rdata = req_sel ? bus.b_rdata : bus.a_rdata;

   bus_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (!issuing),
      .enable (issuing && !sel_ready),
      .expire (expire)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         req_we    <= 1'b0;
         req_sel   <= 1'b0;
         req_addr  <= '0;
         req_wdata <= '0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         rdata_q   <= '0;
      end else begin
         state   <= state_nxt;
         done_q  <= done_nxt;
         err_q   <= err_nxt;
         rdata_q <= rdata_nxt;
         if (state == IDLE && bus.cpu_req) begin
            req_we    <= bus.cpu_we;
            req_sel   <= (bus.cpu_addr >= PERIPH_BASE);
            req_addr  <= bus.cpu_addr;
            req_wdata <= bus.cpu_wdata;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      done_nxt  = 1'b0;
      err_nxt   = 1'b0;
      rdata_nxt = rdata_q;
      case (state)
         IDLE: begin
            if (bus.cpu_req) state_nxt = ISSUE;
         end
         ISSUE: begin
            // A ready in the expiry cycle still completes normally.
            if (sel_ready) begin
               state_nxt = IDLE;
               done_nxt  = 1'b1;
               if (!req_we) rdata_nxt = sel_rdata;
            end else if (expire) begin
               state_nxt = IDLE;
               done_nxt  = 1'b1;
               err_nxt   = 1'b1;
               rdata_nxt = DATA_W'(ERR_DATA);
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Unselected port and idle ports present all-zero fields.
   assign bus.a_valid = issuing && !req_sel;
   assign bus.a_we    = bus.a_valid && req_we;
   assign bus.a_addr  = bus.a_valid ? req_addr  : '0;
   assign bus.a_wdata = bus.a_valid ? req_wdata : '0;
   assign bus.b_valid = issuing && req_sel;
   assign bus.b_we    = bus.b_valid && req_we;
   assign bus.b_addr  = bus.b_valid ? req_addr  : '0;
   assign bus.b_wdata = bus.b_valid ? req_wdata : '0;

   assign bus.cpu_busy  = issuing;
   assign bus.cpu_done  = done_q;
   assign bus.cpu_err   = err_q;
   assign bus.cpu_rdata = rdata_q;
   assign dbg_state     = state;

endmodule

// File: tb/tb_bus_demux.sv
// Directed bench for bus_demux: routing, latency, stalls, timeout, boundaries, reset.
module tb_bus_demux;
  import bus_demux_pkg::*;

  logic   clk;
  logic   rst_n;
  state_t dbg_state;
  int     checks;
  int     errors;

  bus_demux_if #(.DATA_W(32)) bus ();

  bus_demux #(.DATA_W(32), .PERIPH_BASE(32'hFFFF_0000), .TIMEOUT(15)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Outputs are sampled 1 ns after the rising edge; inputs change at the same point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.a_ready = 1'b0; bus.a_rdata = '0; bus.b_ready = 1'b0; bus.b_rdata = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick(); tick();
    checks++;
    if (bus.cpu_busy !== 1'b0 || bus.cpu_done !== 1'b0 || bus.cpu_err !== 1'b0) begin
      errors++; $display("FAIL reset_ctrl busy=%b done=%b err=%b want 0 0 0", bus.cpu_busy, bus.cpu_done, bus.cpu_err);
    end
    checks++;
    if (bus.a_valid !== 1'b0 || bus.b_valid !== 1'b0 || bus.a_addr !== 32'h0 || bus.b_wdata !== 32'h0) begin
      errors++; $display("FAIL reset_ports a_valid=%b b_valid=%b a_addr=%h b_wdata=%h want zeros", bus.a_valid, bus.b_valid, bus.a_addr, bus.b_wdata);
    end
    checks++;
    if (bus.cpu_rdata !== 32'h0 || dbg_state !== IDLE) begin
      errors++; $display("FAIL reset_state rdata=%h state=%0d want 0 0", bus.cpu_rdata, dbg_state);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_read_a();
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h0000_0010;
    bus.a_ready = 1'b1; bus.a_rdata = 32'h1234_5678;
    tick();
    bus.cpu_req = 1'b0;
    checks++;
    if (bus.a_valid !== 1'b1 || bus.b_valid !== 1'b0 || bus.a_addr !== 32'h10 || bus.a_we !== 1'b0) begin
      errors++; $display("FAIL read_a_issue a_valid=%b b_valid=%b a_addr=%h a_we=%b want 1 0 00000010 0", bus.a_valid, bus.b_valid, bus.a_addr, bus.a_we);
    end
    checks++;
    if (bus.cpu_busy !== 1'b1 || bus.cpu_done !== 1'b0) begin
      errors++; $display("FAIL read_a_busy busy=%b done=%b want 1 0", bus.cpu_busy, bus.cpu_done);
    end
    tick();
    bus.a_ready = 1'b0;
    checks++;
    if (bus.cpu_done !== 1'b1 || bus.cpu_err !== 1'b0 || bus.cpu_rdata !== 32'h1234_5678) begin
      errors++; $display("FAIL read_a_done done=%b err=%b rdata=%h want 1 0 12345678", bus.cpu_done, bus.cpu_err, bus.cpu_rdata);
    end
    checks++;
    if (bus.a_valid !== 1'b0 || bus.cpu_busy !== 1'b0) begin
      errors++; $display("FAIL read_a_release a_valid=%b busy=%b want 0 0", bus.a_valid, bus.cpu_busy);
    end
    tick();
    checks++;
    if (bus.cpu_done !== 1'b0) begin
      errors++; $display("FAIL read_a_pulse done=%b want 0", bus.cpu_done);
    end
  endtask

  task automatic test_write_b_delayed();
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 32'hFFFF_0004; bus.cpu_wdata = 32'hA5A5_A5A5;
    bus.b_ready = 1'b0; bus.b_rdata = 32'h5555_AAAA;
    tick();
    bus.cpu_req = 1'b0; bus.cpu_wdata = 32'h0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bus.b_valid !== 1'b1 || bus.b_we !== 1'b1 || bus.b_addr !== 32'hFFFF_0004 || bus.b_wdata !== 32'hA5A5_A5A5) begin
        errors++; $display("FAIL write_b_hold cyc=%0d b_valid=%b b_we=%b b_addr=%h b_wdata=%h want 1 1 ffff0004 a5a5a5a5", i, bus.b_valid, bus.b_we, bus.b_addr, bus.b_wdata);
      end
      checks++;
      if (bus.a_valid !== 1'b0 || bus.cpu_busy !== 1'b1 || bus.cpu_done !== 1'b0) begin
        errors++; $display("FAIL write_b_stall cyc=%0d a_valid=%b busy=%b done=%b want 0 1 0", i, bus.a_valid, bus.cpu_busy, bus.cpu_done);
      end
      if (i == 3) bus.b_ready = 1'b1;
      tick();
    end
    bus.b_ready = 1'b0;
    checks++;
    if (bus.cpu_done !== 1'b1 || bus.cpu_err !== 1'b0 || bus.cpu_rdata !== 32'h1234_5678 || bus.b_valid !== 1'b0) begin
      errors++; $display("FAIL write_b_done done=%b err=%b rdata=%h b_valid=%b want 1 0 12345678 0", bus.cpu_done, bus.cpu_err, bus.cpu_rdata, bus.b_valid);
    end
    tick();
  endtask

  task automatic test_timeout();
    int early;
    early = 0;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'hFFFF_0000; bus.b_ready = 1'b0;
    tick();
    bus.cpu_req = 1'b0;
    for (int i = 1; i < 15; i++) begin
      if (bus.cpu_done !== 1'b0 || bus.b_valid !== 1'b1) early++;
      tick();
    end
    checks++;
    if (early != 0) begin
      errors++; $display("FAIL timeout_wait bad_cycles=%0d want 0", early);
    end
    tick();
    checks++;
    if (bus.cpu_done !== 1'b1 || bus.cpu_err !== 1'b1 || bus.cpu_rdata !== 32'hDEAD_BEEF || bus.b_valid !== 1'b0) begin
      errors++; $display("FAIL timeout_abort done=%b err=%b rdata=%h b_valid=%b want 1 1 deadbeef 0", bus.cpu_done, bus.cpu_err, bus.cpu_rdata, bus.b_valid);
    end
    tick();
    checks++;
    if (bus.cpu_done !== 1'b0 || bus.cpu_err !== 1'b0 || bus.cpu_busy !== 1'b0) begin
      errors++; $display("FAIL timeout_after done=%b err=%b busy=%b want 0 0 0", bus.cpu_done, bus.cpu_err, bus.cpu_busy);
    end
  endtask

  task automatic test_boundary_back_to_back();
    bus.a_ready = 1'b1; bus.a_rdata = 32'h1111_1111;
    bus.b_ready = 1'b1; bus.b_rdata = 32'h2222_2222;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'hFFFE_FFFF;
    tick();
    bus.cpu_addr = 32'hFFFF_0000;
    checks++;
    if (bus.a_valid !== 1'b1 || bus.b_valid !== 1'b0 || bus.a_addr !== 32'hFFFE_FFFF) begin
      errors++; $display("FAIL bound_below a_valid=%b b_valid=%b a_addr=%h want 1 0 fffeffff", bus.a_valid, bus.b_valid, bus.a_addr);
    end
    tick();
    checks++;
    if (bus.cpu_done !== 1'b1 || bus.cpu_rdata !== 32'h1111_1111) begin
      errors++; $display("FAIL bound_below_done done=%b rdata=%h want 1 11111111", bus.cpu_done, bus.cpu_rdata);
    end
    tick();
    bus.cpu_addr = 32'hFFFF_FFFF;
    checks++;
    if (bus.b_valid !== 1'b1 || bus.a_valid !== 1'b0 || bus.b_addr !== 32'hFFFF_0000 || bus.a_addr !== 32'h0) begin
      errors++; $display("FAIL bound_base b_valid=%b a_valid=%b b_addr=%h a_addr=%h want 1 0 ffff0000 0", bus.b_valid, bus.a_valid, bus.b_addr, bus.a_addr);
    end
    tick();
    checks++;
    if (bus.cpu_done !== 1'b1 || bus.cpu_rdata !== 32'h2222_2222) begin
      errors++; $display("FAIL bound_base_done done=%b rdata=%h want 1 22222222", bus.cpu_done, bus.cpu_rdata);
    end
    tick();
    bus.cpu_req = 1'b0;
    checks++;
    if (bus.b_valid !== 1'b1 || bus.a_valid !== 1'b0 || bus.b_addr !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL bound_top b_valid=%b a_valid=%b b_addr=%h want 1 0 ffffffff", bus.b_valid, bus.a_valid, bus.b_addr);
    end
    tick();
    bus.a_ready = 1'b0; bus.b_ready = 1'b0;
    checks++;
    if (bus.cpu_done !== 1'b1 || bus.cpu_busy !== 1'b0) begin
      errors++; $display("FAIL bound_top_done done=%b busy=%b want 1 0", bus.cpu_done, bus.cpu_busy);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 32'h0000_0100; bus.cpu_wdata = 32'hCAFE_0001;
    bus.a_ready = 1'b0;
    tick();
    bus.cpu_req = 1'b0;
    tick();
    checks++;
    if (bus.a_valid !== 1'b1 || bus.a_we !== 1'b1 || bus.a_wdata !== 32'hCAFE_0001) begin
      errors++; $display("FAIL mid_pending a_valid=%b a_we=%b a_wdata=%h want 1 1 cafe0001", bus.a_valid, bus.a_we, bus.a_wdata);
    end
    rst_n = 1'b0;
    tick();
    checks++;
    if (bus.a_valid !== 1'b0 || bus.cpu_busy !== 1'b0 || bus.cpu_done !== 1'b0 || bus.a_addr !== 32'h0) begin
      errors++; $display("FAIL mid_reset a_valid=%b busy=%b done=%b a_addr=%h want 0 0 0 0", bus.a_valid, bus.cpu_busy, bus.cpu_done, bus.a_addr);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (bus.cpu_done !== 1'b0 || bus.cpu_rdata !== 32'h0) begin
      errors++; $display("FAIL mid_nodone done=%b rdata=%h want 0 0", bus.cpu_done, bus.cpu_rdata);
    end
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h0000_0200;
    bus.a_ready = 1'b1; bus.a_rdata = 32'h0BAD_F00D;
    tick();
    bus.cpu_req = 1'b0;
    tick();
    bus.a_ready = 1'b0;
    checks++;
    if (bus.cpu_done !== 1'b1 || bus.cpu_err !== 1'b0 || bus.cpu_rdata !== 32'h0BAD_F00D) begin
      errors++; $display("FAIL mid_fresh done=%b err=%b rdata=%h want 1 0 0badf00d", bus.cpu_done, bus.cpu_err, bus.cpu_rdata);
    end
    tick();
  endtask

  task automatic test_ignore_a_ready();
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'hFFFF_0008;
    bus.a_ready = 1'b1; bus.a_rdata = 32'h7777_7777;
    bus.b_ready = 1'b0; bus.b_rdata = 32'h3333_4444;
    tick();
    bus.cpu_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus.cpu_done !== 1'b0 || bus.b_valid !== 1'b1 || bus.a_valid !== 1'b0) begin
        errors++; $display("FAIL ignore_a cyc=%0d done=%b b_valid=%b a_valid=%b want 0 1 0", i, bus.cpu_done, bus.b_valid, bus.a_valid);
      end
      if (i == 2) bus.b_ready = 1'b1;
      tick();
    end
    bus.a_ready = 1'b0; bus.b_ready = 1'b0;
    checks++;
    if (bus.cpu_done !== 1'b1 || bus.cpu_err !== 1'b0 || bus.cpu_rdata !== 32'h3333_4444) begin
      errors++; $display("FAIL ignore_a_done done=%b err=%b rdata=%h want 1 0 33334444", bus.cpu_done, bus.cpu_err, bus.cpu_rdata);
    end
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    idle_inputs();
    test_reset();
    test_read_a();
    test_write_b_delayed();
    test_timeout();
    test_boundary_back_to_back();
    test_reset_mid();
    test_ignore_a_ready();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
